// File: rtl/inst_cache_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : inst_cache_if                                              |
// | Brief    : Fetch-stage <-> instruction cache request/response port    |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
interface inst_cache_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
);
  logic                   if_to_icache_en_in;
  logic [ADDR_WIDTH-1:0]  if_a_in;
  logic                   icache_to_if_en_out;
  logic [INSTR_WIDTH-1:0] if_d_out;

  modport master (
    output if_to_icache_en_in,
    output if_a_in,
    input  icache_to_if_en_out,
    input  if_d_out
  );

  modport slave (
    input  if_to_icache_en_in,
    input  if_a_in,
    output icache_to_if_en_out,
    output if_d_out
  );
endinterface
`default_nettype wire

// File: rtl/inst_cache.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : inst_cache                                                 |
// | Brief    : Direct-mapped one-word-per-line instruction cache, refills |
// |            misses byte by byte from the memory controller            |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module inst_cache #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int INDEX_BITS  = 8
) (
  input  wire logic                  clk_in,
  input  wire logic                  rst_n_in,
  input  wire logic                  rdy_in,
  input  wire logic                  clear_branch_in,
  inst_cache_if.slave                fetch,
  output logic                       icache_to_mem_en_out,
  output logic [ADDR_WIDTH-1:0]      icache_to_mem_a_out,
  input  wire logic                  mem_to_icache_en_in,
  input  wire logic [7:0]            mem_to_icache_d_in
);
  localparam int c_TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;
  localparam int c_LINES    = 1 << INDEX_BITS;
  localparam int c_BYTES    = INSTR_WIDTH / 8;
  localparam int c_CNT_BITS = $clog2(c_BYTES);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

  state_t                 r_state;
  logic [INSTR_WIDTH-1:0] r_data [c_LINES];
  logic [c_TAG_BITS-1:0]  r_tag  [c_LINES];
  logic [c_LINES-1:0]     r_valid;
  logic [ADDR_WIDTH-3:0]  r_word;
  logic [c_CNT_BITS-1:0]  r_byte_cnt;
  logic [INSTR_WIDTH-1:0] r_fill;
  logic                   r_drop;
  logic                   r_resp_en;
  logic [INSTR_WIDTH-1:0] r_resp_d;
  logic                   r_mem_en;
  logic [ADDR_WIDTH-1:0]  r_mem_a;

  logic [INDEX_BITS-1:0]  w_req_index;
  logic [c_TAG_BITS-1:0]  w_req_tag;
  logic [INDEX_BITS-1:0]  w_fill_index;
  logic [c_TAG_BITS-1:0]  w_fill_tag;
  logic                   w_hit;
  logic                   w_req;
  logic                   w_byte;
  logic                   w_last;
  logic                   w_line_we;
  logic [INSTR_WIDTH-1:0] w_word;
  logic                   w_unused;

  assign w_req_index  = fetch.if_a_in[INDEX_BITS+1:2];
  assign w_req_tag    = fetch.if_a_in[ADDR_WIDTH-1:INDEX_BITS+2];
  assign w_fill_index = r_word[INDEX_BITS-1:0];
  assign w_fill_tag   = r_word[ADDR_WIDTH-3:INDEX_BITS];
  assign w_hit        = r_valid[w_req_index] && (r_tag[w_req_index] == w_req_tag);
  // A request is ignored while a response is on the port or when flushed.
  assign w_req        = fetch.if_to_icache_en_in && !r_resp_en && !clear_branch_in;
  assign w_byte       = (r_state == S_FILL) && rdy_in && mem_to_icache_en_in;
  assign w_last       = (r_byte_cnt == c_CNT_BITS'(c_BYTES - 1));
  assign w_line_we    = w_byte && w_last;
  assign w_unused     = &{1'b0, fetch.if_a_in[1:0]};

  always_comb begin
    w_word = r_fill;
    w_word[8*int'(r_byte_cnt) +: 8] = mem_to_icache_d_in;
  end

  assign fetch.icache_to_if_en_out = r_resp_en;
  assign fetch.if_d_out            = r_resp_d;
  assign icache_to_mem_en_out      = r_mem_en;
  assign icache_to_mem_a_out       = r_mem_a;

  // Line storage carries no reset; r_valid alone decides what is resident.
  always_ff @(posedge clk_in) begin
    if (w_line_we) begin
      r_data[w_fill_index] <= w_word;
      r_tag[w_fill_index]  <= w_fill_tag;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state    <= S_IDLE;
      r_valid    <= '0;
      r_word     <= '0;
      r_byte_cnt <= '0;
      r_fill     <= '0;
      r_drop     <= 1'b0;
      r_resp_en  <= 1'b0;
      r_resp_d   <= '0;
      r_mem_en   <= 1'b0;
      r_mem_a    <= '0;
    end else begin
      // Flush acts regardless of rdy_in.
      if (clear_branch_in && (r_state == S_IDLE)) r_resp_en <= 1'b0;
      if (clear_branch_in && (r_state == S_FILL)) r_drop    <= 1'b1;
      if (rdy_in) begin
        case (r_state)
          S_IDLE: begin
            r_resp_en <= 1'b0;
            if (w_req) begin
              if (w_hit) begin
                r_resp_en <= 1'b1;
                r_resp_d  <= r_data[w_req_index];
              end else begin
                r_state    <= S_FILL;
                r_word     <= fetch.if_a_in[ADDR_WIDTH-1:2];
                r_mem_en   <= 1'b1;
                r_mem_a    <= {fetch.if_a_in[ADDR_WIDTH-1:2], 2'b00};
                r_byte_cnt <= '0;
              end
            end
          end
          S_FILL: begin
            if (mem_to_icache_en_in) begin
              r_fill     <= w_word;
              r_byte_cnt <= r_byte_cnt + c_CNT_BITS'(1);
              r_mem_a    <= r_mem_a + ADDR_WIDTH'(1);
              if (w_last) begin
                r_mem_en              <= 1'b0;
                r_state               <= S_IDLE;
                r_valid[w_fill_index] <= 1'b1;
                r_drop                <= 1'b0;
                if (!(r_drop || clear_branch_in)) begin
                  r_resp_en <= 1'b1;
                  r_resp_d  <= w_word;
                end
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_inst_cache.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_inst_cache                                              |
// | Brief    : Directed + randomized check of inst_cache against a model  |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module tb_inst_cache;
  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        clear_branch_in = 1'b0;
  logic        mem_en_out;
  logic [31:0] mem_a_out;
  logic        mem_en_in = 1'b0;
  logic [7:0]  mem_d_in = 8'h00;

  int n_cmp = 0;
  int n_err = 0;

  inst_cache_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32)) fif ();

  inst_cache #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .INDEX_BITS(8)) dut (
    .clk_in               (clk_in),
    .rst_n_in             (rst_n_in),
    .rdy_in               (rdy_in),
    .clear_branch_in      (clear_branch_in),
    .fetch                (fif),
    .icache_to_mem_en_out (mem_en_out),
    .icache_to_mem_a_out  (mem_a_out),
    .mem_to_icache_en_in  (mem_en_in),
    .mem_to_icache_d_in   (mem_d_in)
  );

  always #5 clk_in = ~clk_in;

  // Reference: backing memory plus which tag each of the 256 lines holds.
  logic [7:0]  mem [logic [31:0]];
  bit          m_valid [256];
  logic [21:0] m_tag   [256];

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = 8'($urandom);
    return mem[a];
  endfunction

  function automatic logic [31:0] word_of(input logic [31:0] base);
    return {mem_byte(base + 3), mem_byte(base + 2), mem_byte(base + 1), mem_byte(base)};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // One fetch as the fetch stage and memory controller would drive it.
  // clr_byte/stall_byte/rst_byte: byte index after which to flush/stall/reset (-1 = never).
  task automatic fetch(input logic [31:0] addr, input int clr_byte, input int stall_byte,
                       input int rst_byte);
    logic [31:0] base;
    int idx;
    bit hit;
    bit dropped;
    base    = {addr[31:2], 2'b00};
    idx     = int'(addr[9:2]);
    hit     = m_valid[idx] && (m_tag[idx] == addr[31:10]);
    dropped = 1'b0;
    fif.if_to_icache_en_in = 1'b1;
    fif.if_a_in            = addr;
    @(negedge clk_in);
    fif.if_to_icache_en_in = 1'b0;
    if (hit) begin
      check_eq("hit_en", 32'(fif.icache_to_if_en_out), 32'd1);
      check_eq("hit_d", fif.if_d_out, word_of(base));
      check_eq("hit_mem_en", 32'(mem_en_out), 32'd0);
    end else begin
      check_eq("miss_en", 32'(fif.icache_to_if_en_out), 32'd0);
      for (int k = 0; k < 4; k++) begin
        int gap;
        gap = int'($urandom_range(0, 2));
        for (int g = 0; g < gap; g++) begin
          check_eq("wait_mem_a", mem_a_out, base + 32'(k));
          @(negedge clk_in);
        end
        check_eq("fill_mem_en", 32'(mem_en_out), 32'd1);
        check_eq("fill_mem_a", mem_a_out, base + 32'(k));
        mem_en_in = 1'b1;
        mem_d_in  = mem_byte(base + 32'(k));
        @(negedge clk_in);
        mem_en_in       = 1'b0;
        clear_branch_in = 1'b0;
        if (k == clr_byte) begin
          clear_branch_in = 1'b1;
          dropped         = 1'b1;
        end
        if (k == stall_byte) begin
          rdy_in = 1'b0;
          for (int s = 0; s < 5; s++) begin
            @(negedge clk_in);
            clear_branch_in = 1'b0;
            check_eq("stall_mem_en", 32'(mem_en_out), 32'd1);
            check_eq("stall_mem_a", mem_a_out, base + 32'(k + 1));
          end
          rdy_in = 1'b1;
        end
        if (k == rst_byte) begin
          #2 rst_n_in = 1'b0;
          #1;
          check_eq("rst_mem_en", 32'(mem_en_out), 32'd0);
          check_eq("rst_mem_a", mem_a_out, 32'd0);
          check_eq("rst_en", 32'(fif.icache_to_if_en_out), 32'd0);
          check_eq("rst_d", fif.if_d_out, 32'd0);
          for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
          @(negedge clk_in);
          rst_n_in = 1'b1;
          @(negedge clk_in);
          return;
        end
      end
      clear_branch_in = 1'b0;
      check_eq("fill_done_mem_en", 32'(mem_en_out), 32'd0);
      check_eq("fill_resp_en", 32'(fif.icache_to_if_en_out), dropped ? 32'd0 : 32'd1);
      if (!dropped) check_eq("fill_resp_d", fif.if_d_out, word_of(base));
      m_valid[idx] = 1'b1;
      m_tag[idx]   = addr[31:10];
    end
    @(negedge clk_in);
    check_eq("pulse_width", 32'(fif.icache_to_if_en_out), 32'd0);
  endtask

  // Request coinciding with a flush: nothing may come back.
  task automatic fetch_with_clear(input logic [31:0] addr);
    fif.if_to_icache_en_in = 1'b1;
    fif.if_a_in            = addr;
    clear_branch_in        = 1'b1;
    @(negedge clk_in);
    fif.if_to_icache_en_in = 1'b0;
    clear_branch_in        = 1'b0;
    check_eq("clr_hit_en", 32'(fif.icache_to_if_en_out), 32'd0);
    check_eq("clr_hit_mem_en", 32'(mem_en_out), 32'd0);
    @(negedge clk_in);
    check_eq("clr_hit_en2", 32'(fif.icache_to_if_en_out), 32'd0);
  endtask

  initial begin
    fif.if_to_icache_en_in = 1'b0;
    fif.if_a_in            = 32'h0;
    for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
    mem[32'h10] = 8'h13; mem[32'h11] = 8'h00; mem[32'h12] = 8'h50; mem[32'h13] = 8'h00;

    repeat (3) @(negedge clk_in);
    check_eq("reset_en", 32'(fif.icache_to_if_en_out), 32'd0);
    check_eq("reset_d", fif.if_d_out, 32'd0);
    check_eq("reset_mem_en", 32'(mem_en_out), 32'd0);
    check_eq("reset_mem_a", mem_a_out, 32'd0);
    rst_n_in = 1'b1;
    @(negedge clk_in);

    fetch(32'h0000_0010, -1, -1, -1);
    check_eq("cold_word", fif.if_d_out, 32'h0050_0013);
    fetch(32'h0000_0010, -1, -1, -1);
    fetch(32'h0000_0410, -1, -1, -1);
    fetch(32'h0000_0010, -1, -1, -1);
    fetch(32'h0000_0020, 1, -1, -1);
    fetch(32'h0000_0020, -1, -1, -1);
    fetch_with_clear(32'h0000_0010);
    fetch(32'h0000_0014, -1, -1, -1);
    fetch(32'h0000_0030, -1, 1, -1);
    fetch(32'h0000_0030, -1, -1, -1);
    fetch(32'h0000_0040, -1, -1, 1);
    fetch(32'h0000_0010, -1, -1, -1);
    fetch(32'hFFFF_FFFC, -1, -1, -1);

    for (int t = 0; t < 60; t++) begin
      logic [31:0] a;
      int mode;
      a    = (32'($urandom_range(0, 2)) << 10) | (32'($urandom_range(0, 7)) << 2)
             | 32'($urandom_range(0, 3));
      mode = int'($urandom_range(0, 9));
      if (mode == 0)      fetch_with_clear(a);
      else if (mode == 1) fetch(a, int'($urandom_range(0, 2)), -1, -1);
      else if (mode == 2) fetch(a, -1, int'($urandom_range(0, 2)), -1);
      else                fetch(a, -1, -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
